// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared constants, state enum and cause helper for intr_ctrl
package intr_ctrl_pkg;

  // Word offsets within the 8-word register window
  localparam logic [2:0] INTC_MTIME_LO    = 3'd0;
  localparam logic [2:0] INTC_MTIME_HI    = 3'd1;
  localparam logic [2:0] INTC_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] INTC_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] INTC_MSIP        = 3'd4;
  localparam logic [2:0] INTC_IRQ_EN      = 3'd5;
  localparam logic [2:0] INTC_EIP         = 3'd6;

  // mcause values for machine external / software / timer interrupts
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  // Enabled-pending vector is {external, software, timer}; external wins
  function automatic logic [31:0] intc_cause(input logic [2:0] pend_en);
    if (pend_en[2]) return CAUSE_MEI;
    else if (pend_en[1]) return CAUSE_MSI;
    else if (pend_en[0]) return CAUSE_MTI;
    else return 32'd0;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - MEM-stage register bus into the interrupt controller
interface intr_ctrl_if;
  logic        bus_sel;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_sel,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_sel,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/intc_timer.sv
// rtl/intc_timer.sv - prescaled 64-bit mtime, mtimecmp and registered compare
module intc_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_mtime_lo,
  input  logic        we_mtime_hi,
  input  logic        we_cmp_lo,
  input  logic        we_cmp_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;
  logic          inc;
  logic          lo_carry;
  logic [31:0]   lo_next;
  logic [31:0]   hi_next;

  assign inc = (pre_cnt == PW'(PRESCALE - 1));

  // Prescaler counts 0..PRESCALE-1 and wraps, producing one increment pulse
  always_ff @(posedge clk) begin
    if (rst) pre_cnt <= '0;
    else if (inc) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  // A CPU write to a half replaces that half's increment; a written low half never carries
  always_comb begin
    lo_carry = inc & (mtime[31:0] == 32'hFFFF_FFFF) & ~we_mtime_lo;
    lo_next  = we_mtime_lo ? wdata : mtime[31:0] + {31'd0, inc};
    hi_next  = we_mtime_hi ? wdata : mtime[63:32] + {31'd0, lo_carry};
  end

  // mtime and mtimecmp storage
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      mtime <= {hi_next, lo_next};
      if (we_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (we_cmp_hi) mtimecmp[63:32] <= wdata;
    end
  end

  // Timer pending is registered so it reflects a compare write one cycle later
  always_ff @(posedge clk) begin
    if (rst) mtip <= 1'b0;
    else mtip <= (mtime >= mtimecmp);
  end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - machine interrupt controller: register decode, pending, priority, request FSM
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  intr_ctrl_if.slave  bus,
  input  logic        ext_irq,
  input  logic        mie_global,
  input  logic        trap_ack,
  input  logic        mret,
  output logic        interrupt,
  output logic [31:0] irq_cause
);

  logic [2:0]  word;
  logic        wr;
  logic        rd;
  logic        unused_addr_bits;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        mtip;
  logic        msip;
  logic [2:0]  irq_en;
  logic        eip;
  logic        ext_s1;
  logic        ext_s2;
  logic        ext_s2_q;
  logic        ext_rise;
  logic        eip_clr;
  logic [2:0]  pend_en;
  logic        req_ok;
  logic [31:0] rd_word;
  logic        latch_cause;
  intc_state_e state;
  intc_state_e state_nxt;

  assign word             = bus.bus_addr[4:2];
  assign unused_addr_bits = ^bus.bus_addr[1:0];
  assign wr               = bus.bus_sel & bus.bus_we;
  assign rd               = bus.bus_sel & ~bus.bus_we;

  intc_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_mtime_lo (wr && (word == INTC_MTIME_LO)),
    .we_mtime_hi (wr && (word == INTC_MTIME_HI)),
    .we_cmp_lo   (wr && (word == INTC_MTIMECMP_LO)),
    .we_cmp_hi   (wr && (word == INTC_MTIMECMP_HI)),
    .wdata       (bus.bus_wdata),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .mtip        (mtip)
  );

  assign ext_rise = ext_s2 & ~ext_s2_q;
  assign eip_clr  = wr && (word == INTC_EIP) && bus.bus_wdata[0];

  // Synchronise the external line, detect its rising edge, latch eip (set beats W1C)
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      ext_s2_q <= 1'b0;
      eip      <= 1'b0;
    end else begin
      ext_s1   <= ext_irq;
      ext_s2   <= ext_s1;
      ext_s2_q <= ext_s2;
      eip      <= ext_rise | (eip & ~eip_clr);
    end
  end

  // Software-interrupt and enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      msip   <= 1'b0;
      irq_en <= 3'd0;
    end else begin
      if (wr && (word == INTC_MSIP)) msip <= bus.bus_wdata[0];
      if (wr && (word == INTC_IRQ_EN)) irq_en <= bus.bus_wdata[2:0];
    end
  end

  // Read mux; reserved word reads as zero
  always_comb begin
    rd_word = 32'd0;
    case (word)
      INTC_MTIME_LO:    rd_word = mtime[31:0];
      INTC_MTIME_HI:    rd_word = mtime[63:32];
      INTC_MTIMECMP_LO: rd_word = mtimecmp[31:0];
      INTC_MTIMECMP_HI: rd_word = mtimecmp[63:32];
      INTC_MSIP:        rd_word = {31'd0, msip};
      INTC_IRQ_EN:      rd_word = {29'd0, irq_en};
      INTC_EIP:         rd_word = {31'd0, eip};
      default:          rd_word = 32'd0;
    endcase
  end

  // Read data captures pre-write state and holds until the next read
  always_ff @(posedge clk) begin
    if (rst) bus.bus_rdata <= 32'd0;
    else if (rd) bus.bus_rdata <= rd_word;
  end

  assign pend_en = {eip, msip, mtip} & irq_en;
  assign req_ok  = mie_global & (|pend_en);

  // Next-state: request, wait for trap entry (ack beats source loss), wait for mret
  always_comb begin
    state_nxt   = state;
    latch_cause = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_ok) begin
          state_nxt   = ST_REQ;
          latch_cause = 1'b1;
        end
      end
      ST_REQ: begin
        if (trap_ack) state_nxt = ST_SERVICE;
        else if (!req_ok) state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (mret) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered request and cause frozen outside the IDLE->REQ edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      irq_cause <= 32'd0;
    end else begin
      state     <= state_nxt;
      interrupt <= (state_nxt == ST_REQ);
      if (latch_cause) irq_cause <= intc_cause(pend_en);
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  word;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq;
  logic        mie_global;
  logic        trap_ack;
  logic        mret;
  logic        interrupt;
  logic [31:0] irq_cause;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  vec_t        tbl[$];

  intr_ctrl_if bus_if ();

  intr_ctrl #(.PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .ext_irq    (ext_irq),
    .mie_global (mie_global),
    .trap_ack   (trap_ack),
    .mret       (mret),
    .interrupt  (interrupt),
    .irq_cause  (irq_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] w, input logic [31:0] d);
    bus_if.bus_sel   = 1'b1;
    bus_if.bus_we    = 1'b1;
    bus_if.bus_addr  = {w, 2'b00};
    bus_if.bus_wdata = d;
    tick();
    bus_if.bus_sel   = 1'b0;
    bus_if.bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] w, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus_if.bus_sel  = 1'b1;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_addr = {w, 2'b00};
    tick();
    bus_if.bus_sel  = 1'b0;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    check(n, bus_if.bus_rdata, e);
  endtask

  task automatic wait_intr(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (interrupt) break;
      tick();
    end
    check(nm, {31'd0, interrupt}, 32'd1);
  endtask

  task automatic check_intr(input string nm, input logic v);
    check(nm, {31'd0, interrupt}, {31'd0, v});
  endtask

  task automatic pulse_ack();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ext_irq = 1'b0; mie_global = 1'b0; trap_ack = 1'b0; mret = 1'b0;
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_addr = 5'd0; bus_if.bus_wdata = 32'd0;

    tbl.push_back('{1'b0, 3'd0, 32'd0, 32'h0000_0000, "rst_mtime_lo"});
    tbl.push_back('{1'b0, 3'd1, 32'd0, 32'h0000_0000, "rst_mtime_hi"});
    tbl.push_back('{1'b0, 3'd2, 32'd0, 32'hFFFF_FFFF, "rst_cmp_lo"});
    tbl.push_back('{1'b0, 3'd3, 32'd0, 32'hFFFF_FFFF, "rst_cmp_hi"});
    tbl.push_back('{1'b0, 3'd4, 32'd0, 32'h0000_0000, "rst_msip"});
    tbl.push_back('{1'b0, 3'd5, 32'd0, 32'h0000_0000, "rst_irq_en"});
    tbl.push_back('{1'b0, 3'd6, 32'd0, 32'h0000_0000, "rst_eip"});
    tbl.push_back('{1'b0, 3'd7, 32'd0, 32'h0000_0000, "rst_rsvd"});
    tbl.push_back('{1'b1, 3'd4, 32'h0000_0001, 32'd0, "wr_msip"});
    tbl.push_back('{1'b0, 3'd4, 32'd0, 32'h0000_0001, "rd_msip1"});
    tbl.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0, "wr_irq_en"});
    tbl.push_back('{1'b0, 3'd5, 32'd0, 32'h0000_0007, "rd_irq_en_mask"});
    tbl.push_back('{1'b1, 3'd7, 32'hDEAD_BEEF, 32'd0, "wr_rsvd"});
    tbl.push_back('{1'b0, 3'd7, 32'd0, 32'h0000_0000, "rd_rsvd"});
    tbl.push_back('{1'b1, 3'd4, 32'h0000_0000, 32'd0, "wr_msip0"});
    tbl.push_back('{1'b0, 3'd4, 32'd0, 32'h0000_0000, "rd_msip0"});
    tbl.push_back('{1'b1, 3'd5, 32'h0000_0000, 32'd0, "wr_irq_en0"});
    tbl.push_back('{1'b0, 3'd5, 32'd0, 32'h0000_0000, "rd_irq_en0"});
    tbl.push_back('{1'b1, 3'd2, 32'h0000_1234, 32'd0, "wr_cmp_lo"});
    tbl.push_back('{1'b0, 3'd2, 32'd0, 32'h0000_1234, "rd_cmp_lo"});
    tbl.push_back('{1'b1, 3'd3, 32'h0000_5678, 32'd0, "wr_cmp_hi"});
    tbl.push_back('{1'b0, 3'd3, 32'd0, 32'h0000_5678, "rd_cmp_hi"});

    tick();
    tick();
    rst = 1'b0;
    check("rst_interrupt", {31'd0, interrupt}, 32'd0);
    check("rst_cause", irq_cause, 32'd0);
    check("rst_rdata", bus_if.bus_rdata, 32'd0);

    // Register map: reads start in the first cycle after reset so mtime is still 0
    foreach (tbl[i]) begin
      if (tbl[i].we) bus_write(tbl[i].word, tbl[i].wdata);
      else bus_read(tbl[i].word, tbl[i].exp, tbl[i].name);
      check_intr({tbl[i].name, "_intr"}, 1'b0);
    end

    // Timer: mtime restarted at 0, cmp=20 -> request when mtime has reached 22
    bus_write(INTC_MTIMECMP_HI, 32'd0);
    bus_write(INTC_MTIME_LO, 32'd0);
    bus_write(INTC_MTIMECMP_LO, 32'd20);
    bus_write(INTC_IRQ_EN, 32'd1);
    mie_global = 1'b1;
    wait_intr("mti_raise");
    check("mti_cause", irq_cause, CAUSE_MTI);
    bus_read(INTC_MTIME_LO, 32'd22, "mti_latency");
    pulse_ack();
    check_intr("mti_ack_drop", 1'b0);
    tick();
    tick();
    check_intr("mti_service", 1'b0);
    pulse_mret();
    check_intr("mti_mret_idle", 1'b0);
    tick();
    check_intr("mti_reraise", 1'b1);
    check("mti_reraise_cause", irq_cause, CAUSE_MTI);
    bus_write(INTC_MTIMECMP_HI, 32'hFFFF_FFFF);
    bus_write(INTC_MTIMECMP_LO, 32'hFFFF_FFFF);
    bus_write(INTC_IRQ_EN, 32'd0);
    tick();
    tick();
    check_intr("mti_cleared", 1'b0);

    // mtime wrap: low-half carry overridden by the high-half write, then full 64-bit wrap
    bus_write(INTC_MTIME_LO, 32'hFFFF_FFFF);
    bus_write(INTC_MTIME_HI, 32'd0);
    bus_read(INTC_MTIME_LO, 32'd0, "wrap32_lo");
    bus_read(INTC_MTIME_HI, 32'd0, "wrap32_hi");
    bus_write(INTC_MTIME_HI, 32'hFFFF_FFFF);
    bus_write(INTC_MTIME_LO, 32'hFFFF_FFFF);
    bus_read(INTC_MTIME_HI, 32'hFFFF_FFFF, "wrap64_pre");
    bus_read(INTC_MTIME_HI, 32'd0, "wrap64_hi");
    bus_read(INTC_MTIME_LO, 32'd1, "wrap64_lo");

    // Software source lost while requesting: drops two cycles after the write
    bus_write(INTC_MSIP, 32'd1);
    bus_write(INTC_IRQ_EN, 32'd2);
    wait_intr("msi_raise");
    check("msi_cause", irq_cause, CAUSE_MSI);
    bus_write(INTC_MSIP, 32'd0);
    check_intr("msi_drop_hold", 1'b1);
    tick();
    check_intr("msi_drop", 1'b0);

    // trap_ack coincident with source clear: ack wins, nothing re-requests after mret
    bus_write(INTC_MSIP, 32'd1);
    wait_intr("msi_raise2");
    trap_ack = 1'b1;
    bus_write(INTC_MSIP, 32'd0);
    trap_ack = 1'b0;
    check_intr("msi_ack_wins", 1'b0);
    pulse_mret();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_intr("msi_no_spurious", 1'b0);
    end

    // Priority: software request latched, then external arrives while in REQ
    bus_write(INTC_MTIMECMP_HI, 32'd0);
    bus_write(INTC_MTIMECMP_LO, 32'd0);
    bus_write(INTC_MSIP, 32'd1);
    bus_write(INTC_IRQ_EN, 32'd7);
    wait_intr("prio_raise");
    check("prio_cause_msi", irq_cause, CAUSE_MSI);
    ext_irq = 1'b1;
    bus_read(INTC_EIP, 32'd0, "eip_edge0");
    bus_read(INTC_EIP, 32'd0, "eip_edge1");
    bus_read(INTC_EIP, 32'd0, "eip_edge2");
    bus_read(INTC_EIP, 32'd1, "eip_edge3");
    check("prio_cause_frozen", irq_cause, CAUSE_MSI);
    check_intr("prio_still_req", 1'b1);
    pulse_ack();
    check_intr("prio_service", 1'b0);
    pulse_mret();
    tick();
    check_intr("prio_reraise", 1'b1);
    check("prio_cause_mei", irq_cause, CAUSE_MEI);

    // eip write-1-to-clear, and set winning over a coincident clear (in SERVICE)
    pulse_ack();
    ext_irq = 1'b0;
    tick();
    tick();
    tick();
    bus_write(INTC_EIP, 32'd1);
    bus_read(INTC_EIP, 32'd0, "eip_w1c");
    ext_irq = 1'b1;
    tick();
    tick();
    bus_write(INTC_EIP, 32'd1);
    bus_read(INTC_EIP, 32'd1, "eip_set_wins");
    check_intr("svc_quiet", 1'b0);

    // Reset from SERVICE with eip set
    ext_irq = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_intr("rst2_interrupt", 1'b0);
    check("rst2_cause", irq_cause, 32'd0);
    check("rst2_rdata", bus_if.bus_rdata, 32'd0);
    bus_read(INTC_MTIME_LO, 32'd0, "rst2_mtime");
    bus_read(INTC_EIP, 32'd0, "rst2_eip");
    bus_read(INTC_IRQ_EN, 32'd0, "rst2_irq_en");
    tick();
    tick();
    check_intr("rst2_quiet", 1'b0);
    bus_write(INTC_MSIP, 32'd1);
    bus_write(INTC_IRQ_EN, 32'd2);
    wait_intr("rst2_idle_reqs");
    check("rst2_req_cause", irq_cause, CAUSE_MSI);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
